interrupt_controller: RTL

- Upstream interrupt front-end for the multicycle MIPS Controller.
- Detects rising edges on external IRQ lines and the NMI line, and holds them pending under a mask register and a global disable.
- Presents one request at a time to the Controller on INT/NMI, supplies the handler vector and source ID, and retires the request when the Controller pulses INA.
- Blocks further requests until software signals end-of-interrupt (eoi).

---
 rtl/cpu_pkg.sv | 18 +
 rtl/irq_priority_encoder.sv | 36 +++
 rtl/interrupt_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the interrupt front-end of the multicycle MIPS controller.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [3:0] IRQ_ID_NMI = 4'd15;
  localparam int         VEC_STRIDE = 4;

  // IRQ i lives one stride above the NMI slot at base, so index 0 maps to base + 4.
  function automatic logic [31:0] irq_vector(input logic [31:0] base, input logic [3:0] idx);
    return base + 32'(VEC_STRIDE) * (32'(idx) + 32'd1);
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-index-first priority encoder; valid only when enabled and at least one request is set.
module irq_priority_encoder #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic         en,
  output logic         valid,
  output logic [3:0]   idx
);

  logic [N-1:0] seen;
  logic [N-1:0] first;

  assign seen[0] = 1'b0;

  // seen[i] is set when any lower-index request is active, so first is one-hot.
  for (genvar gi = 1; gi < N; gi++) begin : g_seen
    assign seen[gi] = seen[gi-1] | req[gi-1];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_first
    assign first[gi] = req[gi] & ~seen[gi];
  end

  assign valid = en & (|req);

  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (first[i]) begin
        idx = idx | 4'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-detecting interrupt front-end: holds pending requests, presents one at a time on INT/NMI
// with its vector and source ID, retires it on INA and waits for eoi before selecting again.
module interrupt_controller
  import cpu_pkg::*;
#(
  parameter int          NUM_IRQ  = 8,
  parameter logic [31:0] VEC_BASE = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               intd_we,
  input  logic               intd_wdata,
  input  logic               eoi,
  input  logic               INA,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic [31:0]        vector,
  output logic [3:0]         irq_id
);

  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               nmi_pend_q, nmi_pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               intd_q, intd_d;
  logic               int_q, int_d;
  logic               nmi_q, nmi_d;
  logic [31:0]        vector_q, vector_d;
  logic [3:0]         irq_id_q, irq_id_d;

  logic [NUM_IRQ-1:0] irq_rise;
  logic               nmi_rise;
  logic [NUM_IRQ-1:0] pend_clr;
  logic               nmi_clr;
  logic [NUM_IRQ-1:0] sel_onehot;
  logic               withdraw;
  logic               enc_valid;
  logic [3:0]         enc_idx;

  irq_priority_encoder #(
    .N(NUM_IRQ)
  ) u_prio (
    .req  (pending_q & mask_q),
    .en   (~intd_q),
    .valid(enc_valid),
    .idx  (enc_idx)
  );

  // One-hot of the source currently latched in irq_id, used for retire and withdraw.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sel
    assign sel_onehot[gi] = (irq_id_q == 4'(gi));
  end

  assign irq_rise = irq_in & ~irq_prev_q;
  assign nmi_rise = nmi_in & ~nmi_prev_q;

  // A presented maskable request is pulled back when its mask bit or the global enable goes away.
  assign withdraw = (mask_we & (|(sel_onehot & ~mask_wdata))) | (intd_we & intd_wdata);

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    nmi_d    = nmi_q;
    vector_d = vector_q;
    irq_id_d = irq_id_q;
    pend_clr = '0;
    nmi_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (nmi_pend_q) begin
          state_d  = REQ;
          nmi_d    = 1'b1;
          vector_d = VEC_BASE;
          irq_id_d = IRQ_ID_NMI;
        end else if (enc_valid) begin
          state_d  = REQ;
          int_d    = 1'b1;
          vector_d = irq_vector(VEC_BASE, enc_idx);
          irq_id_d = enc_idx;
        end
      end
      REQ: begin
        if (INA) begin
          state_d = SERVICE;
          int_d   = 1'b0;
          nmi_d   = 1'b0;
          if (nmi_q) begin
            nmi_clr = 1'b1;
          end else begin
            pend_clr = sel_onehot;
          end
        end else if (int_q && withdraw) begin
          state_d = IDLE;
          int_d   = 1'b0;
        end
      end
      SERVICE: begin
        int_d = 1'b0;
        nmi_d = 1'b0;
        if (eoi) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        int_d   = 1'b0;
        nmi_d   = 1'b0;
      end
    endcase

    // New edges are applied after the retire clear so a same-cycle rise stays pending.
    pending_d  = (pending_q & ~pend_clr) | irq_rise;
    nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_rise;
    irq_prev_d = irq_in;
    nmi_prev_d = nmi_in;
    mask_d     = mask_we ? mask_wdata : mask_q;
    intd_d     = intd_we ? intd_wdata : intd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      nmi_prev_q <= 1'b0;
      pending_q  <= '0;
      nmi_pend_q <= 1'b0;
      mask_q     <= '0;
      intd_q     <= 1'b1;
      int_q      <= 1'b0;
      nmi_q      <= 1'b0;
      vector_q   <= 32'd0;
      irq_id_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      nmi_prev_q <= nmi_prev_d;
      pending_q  <= pending_d;
      nmi_pend_q <= nmi_pend_d;
      mask_q     <= mask_d;
      intd_q     <= intd_d;
      int_q      <= int_d;
      nmi_q      <= nmi_d;
      vector_q   <= vector_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign INT     = int_q;
  assign NMI     = nmi_q;
  assign INTD    = intd_q;
  assign mask    = mask_q;
  assign pending = pending_q;
  assign vector  = vector_q;
  assign irq_id  = irq_id_q;

endmodule
